// File: rtl/mgmt_pwrgood_monitor_if.sv
// Power-good monitor signal bundle: raw domain levels and software controls in,
// qualified status and interrupt out.
interface mgmt_pwrgood_monitor_if #(
    parameter int NUM_DOMAINS = 2
);
    logic [NUM_DOMAINS-1:0] vdd_logic1_raw;
    logic [NUM_DOMAINS-1:0] domain_en;
    logic [NUM_DOMAINS-1:0] loss_clr;
    logic [NUM_DOMAINS-1:0] pwrgood;
    logic [NUM_DOMAINS-1:0] loss_flag;
    logic                   irq;

    modport master (
        output vdd_logic1_raw, domain_en, loss_clr,
        input  pwrgood, loss_flag, irq
    );

    modport slave (
        input  vdd_logic1_raw, domain_en, loss_clr,
        output pwrgood, loss_flag, irq
    );
endinterface

// File: rtl/mgmt_pwrgood_monitor.sv
// Per-domain synchronise / debounce / enable-gate of level-shifted "domain powered"
// levels, producing qualified power-good, sticky loss flags and a management irq.
module mgmt_pwrgood_monitor #(
    parameter int NUM_DOMAINS     = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    resetb,
    mgmt_pwrgood_monitor_if.slave   mon
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_QUAL = 2'd1,
        ST_GOOD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q [NUM_DOMAINS];
    state_t                 state_q [NUM_DOMAINS];
    logic [CNT_W-1:0]       cnt_q [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] pwrgood_q;
    logic [NUM_DOMAINS-1:0] loss_q;
    logic                   irq_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
            pwrgood_q <= '0;
            loss_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                // The last chain stage is the only point the FSM looks at.
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], mon.vdd_logic1_raw[i]};

                // Clear first so a same-edge loss below overrides it.
                if (mon.loss_clr[i])
                    loss_q[i] <= 1'b0;

                case (state_q[i])
                    ST_OFF: begin
                        if (mon.domain_en[i] && sync_q[i][SYNC_STAGES-1]) begin
                            state_q[i] <= ST_QUAL;
                            cnt_q[i]   <= CNT_ONE;
                        end else begin
                            cnt_q[i]   <= '0;
                        end
                    end
                    ST_QUAL: begin
                        if (!mon.domain_en[i] || !sync_q[i][SYNC_STAGES-1]) begin
                            state_q[i] <= ST_OFF;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i]   <= ST_GOOD;
                            pwrgood_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_GOOD: begin
                        if (!mon.domain_en[i]) begin
                            state_q[i]   <= ST_OFF;
                            cnt_q[i]     <= '0;
                            pwrgood_q[i] <= 1'b0;
                        end else if (!sync_q[i][SYNC_STAGES-1]) begin
                            state_q[i]   <= ST_OFF;
                            cnt_q[i]     <= '0;
                            pwrgood_q[i] <= 1'b0;
                            loss_q[i]    <= 1'b1;
                        end
                    end
                    default: begin
                        state_q[i]   <= ST_OFF;
                        cnt_q[i]     <= '0;
                        pwrgood_q[i] <= 1'b0;
                    end
                endcase
            end

            // Deliberately one edge behind loss_flag.
            irq_q <= |loss_q;
        end
    end

    assign mon.pwrgood   = pwrgood_q;
    assign mon.loss_flag = loss_q;
    assign mon.irq       = irq_q;
endmodule

// File: tb/tb_mgmt_pwrgood_monitor.sv
// Directed self-checking bench for mgmt_pwrgood_monitor (2 domains, 2 sync stages,
// 16-cycle debounce).
module tb_mgmt_pwrgood_monitor;
    logic clock;
    logic resetb;
    int   checks;
    int   failures;

    mgmt_pwrgood_monitor_if #(.NUM_DOMAINS(2)) mon ();

    mgmt_pwrgood_monitor #(
        .NUM_DOMAINS    (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clock (clock),
        .resetb(resetb),
        .mon   (mon)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Reset with the given inputs; returns just after release, clear of any edge.
    task automatic apply_reset(input logic [1:0] raw, input logic [1:0] en);
        resetb = 1'b0;
        mon.vdd_logic1_raw = raw;
        mon.domain_en = en;
        mon.loss_clr = 2'b00;
        ticks(2);
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        mon.vdd_logic1_raw = 2'b11;
        mon.domain_en = 2'b11;
        mon.loss_clr = 2'b00;
        ticks(3);
        checks++;
        if (mon.pwrgood !== 2'b00) begin
            failures++; $display("FAIL reset_pwrgood got=%b exp=%b", mon.pwrgood, 2'b00);
        end
        checks++;
        if (mon.loss_flag !== 2'b00) begin
            failures++; $display("FAIL reset_loss got=%b exp=%b", mon.loss_flag, 2'b00);
        end
        checks++;
        if (mon.irq !== 1'b0) begin
            failures++; $display("FAIL reset_irq got=%b exp=%b", mon.irq, 1'b0);
        end
        resetb = 1'b1;
        ticks(17);
        checks++;
        if (mon.pwrgood !== 2'b00) begin
            failures++; $display("FAIL release_edge17 got=%b exp=%b", mon.pwrgood, 2'b00);
        end
        tick();
        checks++;
        if (mon.pwrgood !== 2'b11) begin
            failures++; $display("FAIL release_edge18 got=%b exp=%b", mon.pwrgood, 2'b11);
        end
    endtask

    task automatic test_enable_mask();
        apply_reset(2'b10, 2'b01);
        ticks(4);
        mon.vdd_logic1_raw = 2'b11;
        ticks(17);
        checks++;
        if (mon.pwrgood !== 2'b00) begin
            failures++; $display("FAIL enmask_edge17 got=%b exp=%b", mon.pwrgood, 2'b00);
        end
        tick();
        checks++;
        if (mon.pwrgood !== 2'b01) begin
            failures++; $display("FAIL enmask_edge18 got=%b exp=%b", mon.pwrgood, 2'b01);
        end
        ticks(5);
        checks++;
        if (mon.pwrgood !== 2'b01) begin
            failures++; $display("FAIL enmask_dom1_off got=%b exp=%b", mon.pwrgood, 2'b01);
        end
    endtask

    task automatic test_debounce();
        apply_reset(2'b00, 2'b01);
        ticks(3);
        mon.vdd_logic1_raw = 2'b01;
        ticks(10);
        mon.vdd_logic1_raw = 2'b00;
        tick();
        mon.vdd_logic1_raw = 2'b01;
        ticks(17);
        checks++;
        if (mon.pwrgood !== 2'b00) begin
            failures++; $display("FAIL debounce_edge17 got=%b exp=%b", mon.pwrgood, 2'b00);
        end
        tick();
        checks++;
        if (mon.pwrgood !== 2'b01) begin
            failures++; $display("FAIL debounce_edge18 got=%b exp=%b", mon.pwrgood, 2'b01);
        end
        checks++;
        if (mon.loss_flag !== 2'b00) begin
            failures++; $display("FAIL debounce_loss got=%b exp=%b", mon.loss_flag, 2'b00);
        end
    endtask

    task automatic test_loss_irq();
        apply_reset(2'b01, 2'b11);
        ticks(20);
        checks++;
        if (mon.pwrgood !== 2'b01) begin
            failures++; $display("FAIL loss_pre_good got=%b exp=%b", mon.pwrgood, 2'b01);
        end
        mon.vdd_logic1_raw = 2'b00;
        ticks(2);
        checks++;
        if (mon.pwrgood !== 2'b01) begin
            failures++; $display("FAIL loss_edge2_pg got=%b exp=%b", mon.pwrgood, 2'b01);
        end
        tick();
        checks++;
        if (mon.pwrgood !== 2'b00) begin
            failures++; $display("FAIL loss_edge3_pg got=%b exp=%b", mon.pwrgood, 2'b00);
        end
        checks++;
        if (mon.loss_flag !== 2'b01) begin
            failures++; $display("FAIL loss_edge3_flag got=%b exp=%b", mon.loss_flag, 2'b01);
        end
        checks++;
        if (mon.irq !== 1'b0) begin
            failures++; $display("FAIL loss_edge3_irq got=%b exp=%b", mon.irq, 1'b0);
        end
        tick();
        checks++;
        if (mon.irq !== 1'b1) begin
            failures++; $display("FAIL loss_edge4_irq got=%b exp=%b", mon.irq, 1'b1);
        end
        mon.loss_clr = 2'b01;
        tick();
        mon.loss_clr = 2'b00;
        checks++;
        if (mon.loss_flag !== 2'b00) begin
            failures++; $display("FAIL clr_flag got=%b exp=%b", mon.loss_flag, 2'b00);
        end
        checks++;
        if (mon.irq !== 1'b1) begin
            failures++; $display("FAIL clr_irq_hold got=%b exp=%b", mon.irq, 1'b1);
        end
        tick();
        checks++;
        if (mon.irq !== 1'b0) begin
            failures++; $display("FAIL clr_irq_drop got=%b exp=%b", mon.irq, 1'b0);
        end
    endtask

    task automatic test_en_drop_and_clr_race();
        apply_reset(2'b11, 2'b11);
        ticks(20);
        checks++;
        if (mon.pwrgood !== 2'b11) begin
            failures++; $display("FAIL endrop_pre got=%b exp=%b", mon.pwrgood, 2'b11);
        end
        mon.domain_en = 2'b10;
        tick();
        checks++;
        if (mon.pwrgood !== 2'b10) begin
            failures++; $display("FAIL endrop_pg got=%b exp=%b", mon.pwrgood, 2'b10);
        end
        checks++;
        if (mon.loss_flag !== 2'b00) begin
            failures++; $display("FAIL endrop_loss got=%b exp=%b", mon.loss_flag, 2'b00);
        end
        mon.vdd_logic1_raw = 2'b01;
        ticks(2);
        mon.loss_clr = 2'b10;
        tick();
        mon.loss_clr = 2'b00;
        checks++;
        if (mon.loss_flag !== 2'b10) begin
            failures++; $display("FAIL race_set_wins got=%b exp=%b", mon.loss_flag, 2'b10);
        end
        tick();
        checks++;
        if (mon.irq !== 1'b1) begin
            failures++; $display("FAIL race_irq got=%b exp=%b", mon.irq, 1'b1);
        end
        mon.loss_clr = 2'b10;
        tick();
        mon.loss_clr = 2'b00;
        checks++;
        if (mon.loss_flag !== 2'b00) begin
            failures++; $display("FAIL race_then_clr got=%b exp=%b", mon.loss_flag, 2'b00);
        end
    endtask

    task automatic test_reset_mid_qual();
        apply_reset(2'b11, 2'b11);
        ticks(20);
        mon.vdd_logic1_raw = 2'b01;
        ticks(4);
        mon.domain_en = 2'b10;
        tick();
        mon.domain_en = 2'b11;
        // Domain 0 re-enters QUAL on the next edge with cnt=1; 8 more reach cnt=9.
        ticks(9);
        checks++;
        if ({mon.pwrgood, mon.loss_flag, mon.irq} !== 5'b00_10_1) begin
            failures++;
            $display("FAIL midqual_pre got=%b exp=%b", {mon.pwrgood, mon.loss_flag, mon.irq}, 5'b00_10_1);
        end
        resetb = 1'b0;
        #2;
        checks++;
        if ({mon.pwrgood, mon.loss_flag, mon.irq} !== 5'b00_00_0) begin
            failures++;
            $display("FAIL midqual_async got=%b exp=%b", {mon.pwrgood, mon.loss_flag, mon.irq}, 5'b00_00_0);
        end
        #2;
        resetb = 1'b1;
        ticks(17);
        checks++;
        if (mon.pwrgood !== 2'b00) begin
            failures++; $display("FAIL midqual_edge17 got=%b exp=%b", mon.pwrgood, 2'b00);
        end
        tick();
        checks++;
        if (mon.pwrgood !== 2'b01) begin
            failures++; $display("FAIL midqual_edge18 got=%b exp=%b", mon.pwrgood, 2'b01);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        resetb = 1'b0;
        mon.vdd_logic1_raw = 2'b00;
        mon.domain_en = 2'b00;
        mon.loss_clr = 2'b00;
        #3;
        test_reset();
        test_enable_mask();
        test_debounce();
        test_loss_irq();
        test_en_drop_and_clr_race();
        test_reset_mid_qual();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
